calc_operand_entry: RTL

Keypad-side operand sequencer for the calculator datapath. It accepts decoded key pulses, builds decimal operand A, latches the operator, and builds operand B. On '=' it presents A, B and the operator as held bit-per-port operands to the arithmetic units (add/sub/mul/div) with a one-cycle go strobe. It sits directly upstream of the divider and its sibling units, and it blocks divide-by-zero before issue.

---
 rtl/calc_operand_entry.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/calc_operand_entry.sv
// Keypad-side operand sequencer for the calculator datapath.
// Builds decimal operand A, latches an operator, builds operand B, and on '='
// issues a one-cycle go strobe with A/B/op held stable for the arithmetic units.
// Divide-by-zero is caught here and parked in ERR until CLR.
module calc_operand_entry #(
  parameter int MAX_VAL = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       A1,
  output logic       A2,
  output logic       A3,
  output logic       A4,
  output logic       B1,
  output logic       B2,
  output logic       B3,
  output logic       B4,
  output logic [1:0] op_sel,
  output logic       go,
  output logic       div_by_zero,
  output logic       key_err,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    ENT_A = 2'b00,
    ENT_B = 2'b01,
    DONE  = 2'b10,
    ERR   = 2'b11
  } state_t;

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_DIV = 4'd13;
  localparam logic [3:0] KEY_EQ  = 4'd14;
  localparam logic [3:0] KEY_CLR = 4'd15;
  localparam logic [7:0] MAX8    = 8'(MAX_VAL);

  state_t     state, state_n;
  logic [3:0] a_val, a_n;
  logic [3:0] b_val, b_n;
  logic       a_seen, a_seen_n;
  logic       b_seen, b_seen_n;
  logic [1:0] op_q, op_n;
  logic       go_q, go_n;
  logic       dbz_q, dbz_n;
  logic       kerr_q, kerr_n;

  // Candidate values after appending the pressed digit; 8 bits holds 15*10+9.
  logic [7:0] a_acc, b_acc;
  logic [3:0] op_full;
  logic       is_digit, is_op;

  assign a_acc    = {4'b0, a_val} * 8'd10 + {4'b0, key_code};
  assign b_acc    = {4'b0, b_val} * 8'd10 + {4'b0, key_code};
  assign op_full  = key_code - KEY_ADD;
  assign is_digit = (key_code <= 4'd9);
  assign is_op    = (key_code >= KEY_ADD) && (key_code <= KEY_DIV);

  // State register: every output comes straight from these flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ENT_A;
      a_val  <= '0;
      b_val  <= '0;
      a_seen <= 1'b0;
      b_seen <= 1'b0;
      op_q   <= 2'b00;
      go_q   <= 1'b0;
      dbz_q  <= 1'b0;
      kerr_q <= 1'b0;
    end else begin
      state  <= state_n;
      a_val  <= a_n;
      b_val  <= b_n;
      a_seen <= a_seen_n;
      b_seen <= b_seen_n;
      op_q   <= op_n;
      go_q   <= go_n;
      dbz_q  <= dbz_n;
      kerr_q <= kerr_n;
    end
  end

  // Key interpretation per state; pulses default low, everything else holds.
  always_comb begin
    logic do_clear;
    state_n  = state;
    a_n      = a_val;
    b_n      = b_val;
    a_seen_n = a_seen;
    b_seen_n = b_seen;
    op_n     = op_q;
    dbz_n    = dbz_q;
    go_n     = 1'b0;
    kerr_n   = 1'b0;
    do_clear = 1'b0;

    if (key_valid) begin
      case (state)
        ENT_A: begin
          if (is_digit) begin
            if (a_acc <= MAX8) begin
              a_n      = a_acc[3:0];
              a_seen_n = 1'b1;
            end else begin
              kerr_n = 1'b1;
            end
          end else if (is_op) begin
            op_n     = op_full[1:0];
            b_n      = '0;
            b_seen_n = 1'b0;
            state_n  = ENT_B;
          end else if (key_code == KEY_CLR) begin
            do_clear = 1'b1;
          end
        end
        ENT_B: begin
          if (is_digit) begin
            if (b_acc <= MAX8) begin
              b_n      = b_acc[3:0];
              b_seen_n = 1'b1;
            end else begin
              kerr_n = 1'b1;
            end
          end else if (is_op) begin
            op_n = op_full[1:0];
          end else if (key_code == KEY_EQ) begin
            if (b_seen) begin
              if (op_q == 2'b11 && b_val == 4'd0) begin
                dbz_n   = 1'b1;
                state_n = ERR;
              end else begin
                go_n    = 1'b1;
                state_n = DONE;
              end
            end
          end else begin
            do_clear = 1'b1;
          end
        end
        DONE: begin
          if (is_digit) begin
            a_n      = key_code;
            a_seen_n = 1'b1;
            b_n      = '0;
            b_seen_n = 1'b0;
            state_n  = ENT_A;
          end else if (key_code == KEY_CLR) begin
            do_clear = 1'b1;
          end
        end
        ERR: begin
          if (key_code == KEY_CLR) begin
            do_clear = 1'b1;
          end
        end
        default: state_n = ENT_A;
      endcase
    end

    if (do_clear) begin
      state_n  = ENT_A;
      a_n      = '0;
      b_n      = '0;
      a_seen_n = 1'b0;
      b_seen_n = 1'b0;
      op_n     = 2'b00;
      dbz_n    = 1'b0;
    end
  end

  assign A1          = a_val[0];
  assign A2          = a_val[1];
  assign A3          = a_val[2];
  assign A4          = a_val[3];
  assign B1          = b_val[0];
  assign B2          = b_val[1];
  assign B3          = b_val[2];
  assign B4          = b_val[3];
  assign op_sel      = op_q;
  assign go          = go_q;
  assign div_by_zero = dbz_q;
  assign key_err     = kerr_q;
  assign state_o     = state;

endmodule
